// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_arb_pkg
// Description : Shared types and constants for the SPI flash arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  // Requester indices
  localparam int REQ_DFU = 0;
  localparam int REQ_AUX = 1;

  // Width of the idle-CS timeout counter and the gap counter
  localparam int CNT_W = 16;

  // Saturating increment: holds at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_flash_mux.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_mux
// Description : Owner-select of the flash SPI lines. Without an active grant
//               the flash sees an idle bus (CS high, clock/data low) and both
//               requesters see MISO low.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_mux
  import spi_arb_pkg::*;
(
  input  logic grant_active,
  input  logic owner,
  input  logic m0_csel,
  input  logic m0_sclk,
  input  logic m0_mosi,
  output logic m0_miso,
  input  logic m1_csel,
  input  logic m1_sclk,
  input  logic m1_mosi,
  output logic m1_miso,
  output logic spi_csel,
  output logic spi_clk,
  output logic spi_mosi,
  input  logic spi_miso
);

  // Route the owner's master lines to the flash, idle defaults otherwise
  always_comb begin
    spi_csel = 1'b1;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    m0_miso  = 1'b0;
    m1_miso  = 1'b0;
    if (grant_active) begin
      if (owner == 1'(REQ_AUX)) begin
        spi_csel = m1_csel;
        spi_clk  = m1_sclk;
        spi_mosi = m1_mosi;
        m1_miso  = spi_miso;
      end else begin
        spi_csel = m0_csel;
        spi_clk  = m0_sclk;
        spi_mosi = m0_mosi;
        m0_miso  = spi_miso;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_arbiter
// Description : Two-requester round-robin arbiter for a shared SPI flash,
//               with an enforced CS-high gap between owners and an idle-CS
//               timeout that revokes and locks out a stalled owner.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic       clk_48mhz,
  input  logic       resetn,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic       m0_csel,
  input  logic       m0_sclk,
  input  logic       m0_mosi,
  output logic       m0_miso,
  input  logic       m1_csel,
  input  logic       m1_sclk,
  input  logic       m1_mosi,
  output logic       m1_miso,
  output logic       spi_csel,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       busy,
  output logic       timeout
);

  // A zero gap still costs one GAP cycle; limits beyond the counter saturate
  localparam int               GAP_LEN  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int               CNT_MAX  = (1 << CNT_W) - 1;
  localparam int               TO_SAT   = (TIMEOUT_CYCLES > CNT_MAX) ? CNT_MAX : TIMEOUT_CYCLES;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TO_SAT);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       lock_q, lock_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]       eligible;
  logic             winner;
  logic             grant_active;

  assign eligible     = req & ~lock_q;
  assign grant_active = (state_q == ST_GRANT);

  // Next-state: arbitration, release/timeout handling, gap and idle counters
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    idle_cnt_d = idle_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    timeout_d  = 1'b0;
    winner     = owner_q;
    // A lock survives only while its request stays high
    lock_d     = lock_q & req;

    case (state_q)
      ST_IDLE: begin
        idle_cnt_d = '0;
        if (eligible != 2'b00) begin
          // On a tie the requester that did not win last time goes next
          winner  = (eligible == 2'b11) ? ~last_q : eligible[1];
          owner_d = winner;
          last_d  = winner;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (TO_EN && (idle_cnt_q == TO_LIMIT)) begin
          state_d         = ST_GAP;
          gap_cnt_d       = GAP_LOAD;
          idle_cnt_d      = '0;
          timeout_d       = 1'b1;
          lock_d[owner_q] = 1'b1;
        end else if (!req[owner_q]) begin
          state_d    = ST_GAP;
          gap_cnt_d  = GAP_LOAD;
          idle_cnt_d = '0;
        end else if (spi_csel) begin
          // spi_csel is the owner's CS while granted
          idle_cnt_d = sat_inc(idle_cnt_q);
        end else begin
          idle_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    gnt_d = (state_d == ST_GRANT) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
  end

  // State and registered outputs; reset aborts any transfer immediately
  always_ff @(posedge clk_48mhz or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      gnt_q      <= 2'b00;
      lock_q     <= 2'b00;
      timeout_q  <= 1'b0;
      idle_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      lock_q     <= lock_d;
      timeout_q  <= timeout_d;
      idle_cnt_q <= idle_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign timeout = timeout_q;
  assign busy    = (state_q != ST_IDLE);

  spi_flash_mux u_mux (
    .grant_active (grant_active),
    .owner        (owner_q),
    .m0_csel      (m0_csel),
    .m0_sclk      (m0_sclk),
    .m0_mosi      (m0_mosi),
    .m0_miso      (m0_miso),
    .m1_csel      (m1_csel),
    .m1_sclk      (m1_sclk),
    .m1_mosi      (m1_mosi),
    .m1_miso      (m1_miso),
    .spi_csel     (spi_csel),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso)
  );

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_arbiter
// Description : Self-checking bench for spi_flash_arbiter: a vector table,
//               directed multi-cycle sequences and random traffic compared
//               against a behavioural ownership model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_arbiter;

  localparam int GAP = 4;
  localparam int TO  = 100;

  logic       clk_48mhz = 1'b0;
  logic       resetn;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       m0_csel, m0_sclk, m0_mosi, m0_miso;
  logic       m1_csel, m1_sclk, m1_mosi, m1_miso;
  logic       spi_csel, spi_clk, spi_mosi, spi_miso;
  logic       busy, timeout;
  logic [8:0] dut_vec;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_48mhz = ~clk_48mhz;

  spi_flash_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk_48mhz (clk_48mhz),
    .resetn    (resetn),
    .req       (req),
    .gnt       (gnt),
    .m0_csel   (m0_csel),
    .m0_sclk   (m0_sclk),
    .m0_mosi   (m0_mosi),
    .m0_miso   (m0_miso),
    .m1_csel   (m1_csel),
    .m1_sclk   (m1_sclk),
    .m1_mosi   (m1_mosi),
    .m1_miso   (m1_miso),
    .spi_csel  (spi_csel),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .busy      (busy),
    .timeout   (timeout)
  );

  // {gnt, busy, timeout, spi_csel, spi_clk, spi_mosi, m0_miso, m1_miso}
  assign dut_vec = {gnt, busy, timeout, spi_csel, spi_clk, spi_mosi, m0_miso, m1_miso};

  // ---------------- behavioural model ----------------
  int       m_owner;   // -1: nobody owns the flash
  int       m_gap;     // gap cycles still to serve
  int       m_idle;    // consecutive CS-high cycles of the current owner
  bit       m_last;    // requester that won most recently
  bit [1:0] m_lock;
  bit       m_to;

  task automatic model_reset();
    m_owner = -1;
    m_gap   = 0;
    m_idle  = 0;
    m_last  = 1'b1;
    m_lock  = 2'b00;
    m_to    = 1'b0;
  endtask

  task automatic model_edge();
    logic [1:0] elig;
    logic [1:0] nlock;
    logic       ocs;
    int         gap_len;
    gap_len = (GAP < 1) ? 1 : GAP;
    elig    = req & ~m_lock;
    nlock   = m_lock & req;
    m_to    = 1'b0;
    if (m_owner >= 0) begin
      ocs = (m_owner == 1) ? m1_csel : m0_csel;
      if (TO != 0 && m_idle >= TO) begin
        m_to           = 1'b1;
        nlock[m_owner] = 1'b1;
        m_owner        = -1;
        m_gap          = gap_len;
      end else if (!req[m_owner]) begin
        m_owner = -1;
        m_gap   = gap_len;
      end else if (ocs) begin
        if (m_idle < 65535) m_idle = m_idle + 1;
      end else begin
        m_idle = 0;
      end
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
    end else if (elig != 2'b00) begin
      if (elig == 2'b11) m_owner = m_last ? 0 : 1;
      else               m_owner = elig[1] ? 1 : 0;
      m_last = (m_owner == 1);
      m_idle = 0;
    end
    m_lock = nlock;
  endtask

  function automatic logic [8:0] model_out();
    logic [1:0] g;
    logic       c, s, mo, mi0, mi1, b;
    g = 2'b00; c = 1'b1; s = 1'b0; mo = 1'b0; mi0 = 1'b0; mi1 = 1'b0;
    if (m_owner == 0) begin
      g = 2'b01; c = m0_csel; s = m0_sclk; mo = m0_mosi; mi0 = spi_miso;
    end else if (m_owner == 1) begin
      g = 2'b10; c = m1_csel; s = m1_sclk; mo = m1_mosi; mi1 = spi_miso;
    end
    b = (m_owner >= 0) || (m_gap > 0);
    return {g, b, m_to, c, s, mo, mi0, mi1};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model advances on the edge, outputs compared 1ns later
  task automatic tick();
    @(posedge clk_48mhz);
    model_edge();
    #1;
    check("model", 16'(dut_vec), 16'(model_out()));
    check("gnt_onehot", 16'(gnt == 2'b11), 16'd0);
    check("idle_csel", 16'(gnt == 2'b00 && spi_csel !== 1'b1), 16'd0);
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    req      = 2'b00;
    m0_csel  = 1'b1; m0_sclk = 1'b0; m0_mosi = 1'b0;
    m1_csel  = 1'b1; m1_sclk = 1'b0; m1_mosi = 1'b0;
    spi_miso = 1'b0;
    #1;
    model_reset();
    check("reset_state", 16'(dut_vec), 16'(9'b00_0_0_100_00));
    repeat (2) @(posedge clk_48mhz);
    #1;
    resetn = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [1:0] req;
    logic [2:0] m0;    // {csel, sclk, mosi}
    logic [2:0] m1;
    logic       miso;
    logic [8:0] exp;   // {gnt, busy, timeout, csel, clk, mosi, m0_miso, m1_miso}
  } vec_t;

  vec_t tbl [12];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int to_pulses;
    int gnt_cycles;
    int regrant_bad;
    int w;
    logic [1:0] exp_g;
    bit found;

    tbl[0]  = {2'b00, 3'b100, 3'b100, 1'b0, 9'b00_0_0_100_00};
    tbl[1]  = {2'b01, 3'b100, 3'b100, 1'b1, 9'b01_1_0_100_10};
    tbl[2]  = {2'b01, 3'b011, 3'b100, 1'b0, 9'b01_1_0_011_00};
    tbl[3]  = {2'b01, 3'b001, 3'b011, 1'b1, 9'b01_1_0_001_10};
    tbl[4]  = {2'b11, 3'b000, 3'b000, 1'b1, 9'b01_1_0_000_10};
    tbl[5]  = {2'b10, 3'b100, 3'b000, 1'b1, 9'b00_1_0_100_00};
    tbl[6]  = {2'b10, 3'b100, 3'b011, 1'b1, 9'b00_1_0_100_00};
    tbl[7]  = {2'b10, 3'b100, 3'b011, 1'b1, 9'b00_1_0_100_00};
    tbl[8]  = {2'b10, 3'b100, 3'b011, 1'b1, 9'b00_1_0_100_00};
    tbl[9]  = {2'b10, 3'b100, 3'b011, 1'b1, 9'b00_0_0_100_00};
    tbl[10] = {2'b10, 3'b100, 3'b010, 1'b1, 9'b10_1_0_010_01};
    tbl[11] = {2'b00, 3'b100, 3'b100, 1'b1, 9'b00_1_0_100_00};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req;
      {m0_csel, m0_sclk, m0_mosi} = tbl[i].m0;
      {m1_csel, m1_sclk, m1_mosi} = tbl[i].m1;
      spi_miso = tbl[i].miso;
      tick();
      check("table", 16'(dut_vec), 16'(tbl[i].exp));
    end

    // Both requesting from reset; requester 0 releases, gap, then requester 1
    do_reset();
    req = 2'b11; m0_csel = 1'b0; m1_csel = 1'b0;
    tick();
    check("tie_first_gnt", 16'(gnt), 16'h1);
    repeat (39) tick();
    m0_csel = 1'b1; req = 2'b10;
    tick();
    check("release_gnt", 16'({gnt, spi_csel}), 16'b001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_hold", 16'({busy, gnt, spi_csel}), 16'b1001);
    end
    tick();
    check("gap_done", 16'({busy, gnt}), 16'd0);
    tick();
    check("second_gnt", 16'(gnt), 16'h2);

    // Alternation with both requesters held
    do_reset();
    req = 2'b11; m0_csel = 1'b0; m1_csel = 1'b0;
    exp_g = 2'b01;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (gnt == 2'b00 && w < 20) begin
        tick();
        w++;
      end
      check("alternate", 16'(gnt), 16'(exp_g));
      repeat (20) tick();
      req = ~gnt;
      tick();
      req = 2'b11;
      exp_g = ~exp_g;
    end

    // Idle-CS timeout: one pulse, revoke, lockout until req falls
    do_reset();
    req = 2'b10; m1_csel = 1'b1;
    to_pulses = 0; gnt_cycles = 0; regrant_bad = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (gnt == 2'b10) begin
        gnt_cycles++;
        if (to_pulses != 0) regrant_bad++;
      end
      if (timeout) begin
        to_pulses++;
        check("timeout_gnt", 16'(gnt), 16'd0);
      end
    end
    check("timeout_pulses", 16'(to_pulses), 16'd1);
    check("timeout_len", 16'(gnt_cycles), 16'(TO + 1));
    check("locked_out", 16'(regrant_bad), 16'd0);
    req = 2'b00;
    tick();
    req = 2'b10;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (gnt == 2'b10) found = 1'b1;
    end
    check("unlock_regrant", 16'(found), 16'd1);

    // Asynchronous reset while requester 1 owns with CS low
    do_reset();
    req = 2'b10; m1_csel = 1'b0; m1_sclk = 1'b1;
    tick();
    tick();
    check("owned_before_rst", 16'({gnt, spi_csel, spi_clk}), 16'b1001);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset", 16'({gnt, busy, timeout, spi_csel, spi_clk}), 16'b000010);
    model_reset();
    @(posedge clk_48mhz);
    #1;
    resetn = 1'b1;
    repeat (3) tick();

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 79) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 79) == 0) req[1] = ~req[1];
      if (m0_csel) begin
        if ($urandom_range(0, 199) == 0) m0_csel = 1'b0;
      end else if ($urandom_range(0, 3) == 0) m0_csel = 1'b1;
      if (m1_csel) begin
        if ($urandom_range(0, 199) == 0) m1_csel = 1'b0;
      end else if ($urandom_range(0, 3) == 0) m1_csel = 1'b1;
      m0_sclk  = 1'($urandom_range(0, 1));
      m0_mosi  = 1'($urandom_range(0, 1));
      m1_sclk  = 1'($urandom_range(0, 1));
      m1_mosi  = 1'($urandom_range(0, 1));
      spi_miso = 1'($urandom_range(0, 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
